// File: rtl/moody_pkg.sv
// Shared constants for the mood model: stimulus channel count and the default conditioner tuning.
package moody_pkg;

  localparam int unsigned NStim              = 7;
  localparam int unsigned DebounceCyclesDef  = 8;
  localparam int unsigned HabLimitDef        = 4;
  localparam int unsigned QuietTicksDef      = 2;

endpackage

// File: rtl/debounce_channel.sv
// One stimulus bit: two-flop synchroniser, persistence debouncer and rising-edge pulse.
module debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic rise_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            meta_q, sync_q;
  logic            deb_q, deb_d;
  logic            rise_q;
  logic [CntW-1:0] dcnt_q, dcnt_d;

  // The level is accepted on the cycle the disagreement count would reach DEBOUNCE_CYCLES.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (sync_q != deb_q) begin
      if (dcnt_q == CntLast) begin
        deb_d = sync_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      deb_q  <= 1'b0;
      dcnt_q <= '0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      deb_q  <= deb_d;
      dcnt_q <= dcnt_d;
      rise_q <= deb_d & ~deb_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/stimulus_conditioner.sv
// Conditions raw stimuli for the regulators: debounced rises are held pending, released once per
// heartbeat tick, and suppressed per channel after too many consecutive pressed ticks.
module stimulus_conditioner
  import moody_pkg::*;
#(
  parameter int unsigned N_STIM          = NStim,
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDef,
  parameter int unsigned HAB_LIMIT       = HabLimitDef,
  parameter int unsigned QUIET_TICKS     = QuietTicksDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_STIM-1:0] stim_raw,
  input  logic              tick,
  output logic [N_STIM-1:0] stim_out,
  output logic [N_STIM-1:0] habituated,
  output logic              event_any
);

  localparam int unsigned HabW   = $clog2(HAB_LIMIT + 1);
  localparam int unsigned QuietW = $clog2(QUIET_TICKS + 1);
  localparam logic [HabW-1:0]   HabMax    = HabW'(HAB_LIMIT);
  localparam logic [QuietW-1:0] QuietLast = QuietW'(QUIET_TICKS - 1);

  logic [N_STIM-1:0] rise;
  logic [N_STIM-1:0] pending_q, pending_d;
  logic [N_STIM-1:0] stim_out_q, stim_out_d;
  logic [N_STIM-1:0] habituated_q, habituated_d;
  logic              event_any_q, event_any_d;
  logic [HabW-1:0]   hab_cnt_q [N_STIM];
  logic [HabW-1:0]   hab_cnt_d [N_STIM];
  logic [QuietW-1:0] quiet_cnt_q [N_STIM];
  logic [QuietW-1:0] quiet_cnt_d [N_STIM];

  for (genvar i = 0; i < N_STIM; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i (clk),
      .rst_i (rst),
      .raw_i (stim_raw[i]),
      .rise_o(rise[i])
    );
  end

  // A rise coinciding with tick is not consumed by that tick; it seeds the next period.
  always_comb begin
    pending_d    = tick ? rise : (pending_q | rise);
    stim_out_d   = stim_out_q;
    habituated_d = habituated_q;
    for (int i = 0; i < N_STIM; i++) begin
      hab_cnt_d[i]   = hab_cnt_q[i];
      quiet_cnt_d[i] = quiet_cnt_q[i];
      if (tick) begin
        stim_out_d[i] = pending_q[i] && (hab_cnt_q[i] < HabMax);
        if (pending_q[i]) begin
          quiet_cnt_d[i] = '0;
          if (hab_cnt_q[i] != HabMax) begin
            hab_cnt_d[i] = hab_cnt_q[i] + 1'b1;
          end
        end else if (quiet_cnt_q[i] == QuietLast) begin
          quiet_cnt_d[i] = '0;
          hab_cnt_d[i]   = '0;
        end else begin
          quiet_cnt_d[i] = quiet_cnt_q[i] + 1'b1;
        end
        habituated_d[i] = (hab_cnt_d[i] == HabMax);
      end
    end
    event_any_d = tick && (|stim_out_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      stim_out_q   <= '0;
      habituated_q <= '0;
      event_any_q  <= 1'b0;
      for (int i = 0; i < N_STIM; i++) begin
        hab_cnt_q[i]   <= '0;
        quiet_cnt_q[i] <= '0;
      end
    end else begin
      pending_q    <= pending_d;
      stim_out_q   <= stim_out_d;
      habituated_q <= habituated_d;
      event_any_q  <= event_any_d;
      for (int i = 0; i < N_STIM; i++) begin
        hab_cnt_q[i]   <= hab_cnt_d[i];
        quiet_cnt_q[i] <= quiet_cnt_d[i];
      end
    end
  end

  assign stim_out   = stim_out_q;
  assign habituated = habituated_q;
  assign event_any  = event_any_q;

endmodule

// File: tb/tb_stimulus_conditioner.sv
// Directed scenarios then random traffic, checked every cycle against a behavioural model.
module tb_stimulus_conditioner;

  localparam int NS = 7;
  localparam int DC = 8;
  localparam int HL = 4;
  localparam int QT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] stim_raw = '0;
  logic          tick = 1'b0;
  logic [NS-1:0] stim_out, habituated;
  logic          event_any;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  bit   m_r1 [NS];
  bit   m_r2 [NS];
  bit   m_deb [NS];
  bit   m_rise [NS];
  bit   m_pend [NS];
  int   m_run [NS];
  int   m_hab [NS];
  int   m_quiet [NS];
  logic [NS-1:0] m_out = '0;
  logic [NS-1:0] m_habit = '0;
  logic          m_ev = 1'b0;

  stimulus_conditioner #(
    .N_STIM(NS),
    .DEBOUNCE_CYCLES(DC),
    .HAB_LIMIT(HL),
    .QUIET_TICKS(QT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stim_raw(stim_raw),
    .tick(tick),
    .stim_out(stim_out),
    .habituated(habituated),
    .event_any(event_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NS-1:0] obs, input logic [NS-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Behavioural update for one clock edge, from the inputs present at that edge.
  task automatic model_step();
    logic [NS-1:0] nout;
    nout = m_out;
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        m_r1[i] = 0; m_r2[i] = 0; m_deb[i] = 0; m_rise[i] = 0; m_pend[i] = 0;
        m_run[i] = 0; m_hab[i] = 0; m_quiet[i] = 0;
      end
      m_out = '0; m_habit = '0; m_ev = 1'b0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        bit n_deb, n_rise, n_pend;
        int n_run;
        n_deb = m_deb[i];
        n_run = m_run[i];
        if (m_r2[i] == m_deb[i]) n_run = 0;
        else if (m_run[i] + 1 == DC) begin n_deb = m_r2[i]; n_run = 0; end
        else n_run = m_run[i] + 1;
        n_rise = n_deb && !m_deb[i];
        if (tick) begin
          nout[i] = m_pend[i] && (m_hab[i] < HL);
          n_pend = m_rise[i];
          if (m_pend[i]) begin
            m_quiet[i] = 0;
            m_hab[i] = (m_hab[i] + 1 > HL) ? HL : m_hab[i] + 1;
          end else begin
            m_quiet[i] = m_quiet[i] + 1;
            if (m_quiet[i] == QT) begin m_quiet[i] = 0; m_hab[i] = 0; end
          end
          m_habit[i] = (m_hab[i] == HL);
        end else begin
          n_pend = m_pend[i] || m_rise[i];
        end
        m_r2[i] = m_r1[i];
        m_r1[i] = stim_raw[i];
        m_deb[i] = n_deb;
        m_run[i] = n_run;
        m_rise[i] = n_rise;
        m_pend[i] = n_pend;
      end
      m_out = nout;
      m_ev = tick && (|nout);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("stim_out", stim_out, m_out);
    check("habituated", habituated, m_habit);
    check("event_any", {{(NS-1){1'b0}}, event_any}, {{(NS-1){1'b0}}, m_ev});
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic press(input int ch, input int hi, input int lo);
    stim_raw[ch] = 1'b1;
    idle(hi);
    stim_raw[ch] = 1'b0;
    idle(lo);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
  endtask

  initial begin
    int burst;
    burst = 0;
    idle(2);
    rst = 1'b0;
    check("reset_stim_out", stim_out, 7'h00);
    check("reset_habituated", habituated, 7'h00);

    // Debounce: short glitch ignored, long press gives one event
    press(0, 5, 15);
    press(0, 20, 20);
    check("deb_before_tick", stim_out, 7'h00);
    do_tick();
    check("deb_stim_out", stim_out, 7'h01);
    check("deb_event", {6'b0, event_any}, 7'h01);
    idle(3);
    check("deb_event_once", {6'b0, event_any}, 7'h00);
    check("deb_hold", stim_out, 7'h01);
    do_tick();
    check("deb_next_tick", stim_out, 7'h00);

    // Collapse: three presses in one period make one event
    for (int k = 0; k < 3; k++) press(2, 12, 12);
    do_tick();
    check("collapse_out", stim_out, 7'h04);
    idle(5);
    do_tick();
    check("collapse_next", stim_out, 7'h00);

    // Tick collision: rise lands on the tick cycle
    stim_raw[1] = 1'b1;
    idle(10);
    do_tick();
    check("collision_now", stim_out, 7'h00);
    idle(5);
    stim_raw[1] = 1'b0;
    idle(12);
    do_tick();
    check("collision_next", stim_out, 7'h02);
    do_tick();

    // Habituation on ch3
    for (int k = 0; k < 6; k++) begin
      press(3, 12, 12);
      do_tick();
      check("hab_stim_out", stim_out, (k < HL) ? 7'h08 : 7'h00);
      check("hab_flag", habituated, (k >= HL - 1) ? 7'h08 : 7'h00);
    end

    // Recovery
    idle(4);
    do_tick();
    check("recover_1", habituated, 7'h08);
    idle(4);
    do_tick();
    check("recover_2", habituated, 7'h00);
    press(3, 12, 12);
    do_tick();
    check("recover_pass", stim_out, 7'h08);

    // Reset mid-operation with ch3 habituated and ch4 pending
    for (int k = 0; k < 3; k++) begin
      press(3, 12, 12);
      do_tick();
    end
    check("pre_rst_hab", habituated, 7'h08);
    stim_raw[4] = 1'b1;
    idle(12);
    stim_raw[4] = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_out", stim_out, 7'h00);
    check("mid_rst_hab", habituated, 7'h00);
    check("mid_rst_ev", {6'b0, event_any}, 7'h00);
    idle(12);
    do_tick();
    check("post_rst_tick", stim_out, 7'h00);
    press(3, 12, 12);
    do_tick();
    check("post_rst_press", stim_out, 7'h08);

    // Random traffic, including continuous-tick bursts and occasional resets
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NS; i++)
        if ($urandom_range(0, 23) == 0) stim_raw[i] = ~stim_raw[i];
      if (burst > 0) begin
        tick = 1'b1;
        burst--;
      end else begin
        tick = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 199) == 0) burst = $urandom_range(3, 12);
      end
      rst = ($urandom_range(0, 799) == 0);
      cycle();
    end
    rst = 1'b0;
    tick = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
